// File: rtl/led_pulse_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pulse_ext_pkg
// Purpose  : Shared types and helpers for the LED pulse extender. Holds the
//            per-channel FSM state encoding, the event-counter width and the
//            hold/gap down-counter width function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package led_pulse_ext_pkg;

    typedef enum logic [1:0] {
        LPE_IDLE = 2'd0,
        LPE_HOLD = 2'd1,
        LPE_GAP  = 2'd2
    } lpe_state_e;

    localparam int LPE_CNT_W = 16;

    // The down-counter only ever holds HOLD_CYCLES-1 or GAP_CYCLES-1, so
    // sizing for max(HOLD, GAP) leaves one spare code and keeps the
    // expression valid for the 1-cycle corner case.
    function automatic int lpe_cnt_width(input int hold_cycles, input int gap_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pulse_ext_ch.sv
`default_nettype none
// ============================================================================
// Module   : led_pulse_ext_ch
// Purpose  : One pulse-extender channel: input synchroniser, rising-edge
//            detect, IDLE/HOLD/GAP FSM with a shared down-counter, and an
//            optional saturating accepted-edge counter.
// Ports    : clk       - system clock
//            rst_n     - asynchronous active-low reset
//            pulse_in  - asynchronous event input
//            cnt_clr   - synchronous clear of the event counter
//            pulse_out - registered stretched output
//            evt_cnt   - accepted-edge count (0 when counting is disabled)
// Config   : LED_PULSE_EXT_CNT_EN enables the event counter.
// Revision : 1.0 - initial release
// ============================================================================
module led_pulse_ext_ch
    import led_pulse_ext_pkg::*;
#(
    parameter int HOLD_CYCLES = 80_000_000,
    parameter int GAP_CYCLES  = 8_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int RETRIGGER   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pulse_in,
    input  logic                 cnt_clr,
    output logic                 pulse_out,
    output logic [LPE_CNT_W-1:0] evt_cnt
);

    localparam int             CNT_W     = lpe_cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    // ------------------------------------------------------------------
    // Synchroniser and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed_q;
    logic                   edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            delayed_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            delayed_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~delayed_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    lpe_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             hold_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LPE_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            pulse_out <= hold_active;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        case (state_q)
            LPE_IDLE: begin
                if (edge_det) begin
                    state_d = LPE_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            LPE_HOLD: begin
                if (edge_det && (RETRIGGER != 0)) begin
                    // Retrigger wins even on the terminal count, so the
                    // output never drops when an edge lands on the last cycle.
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    if (GAP_CYCLES == 0) begin
                        if (pending_q || edge_det) begin
                            cnt_d = HOLD_LOAD;
                        end else begin
                            state_d = LPE_IDLE;
                        end
                        pending_d = 1'b0;
                    end else begin
                        state_d   = LPE_GAP;
                        cnt_d     = GAP_LOAD;
                        pending_d = pending_q | edge_det;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (edge_det) begin
                        pending_d = 1'b1;
                    end
                end
            end
            LPE_GAP: begin
                if (cnt_q == '0) begin
                    // An edge on the final gap cycle is honoured directly.
                    if (pending_q || edge_det) begin
                        state_d = LPE_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = LPE_IDLE;
                    end
                    pending_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (edge_det) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = LPE_IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (registered into pulse_out above)
    // ------------------------------------------------------------------
    always_comb begin
        hold_active = 1'b0;
        if (state_q == LPE_HOLD) begin
            hold_active = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Optional accepted-edge counter
    // ------------------------------------------------------------------
`ifdef LED_PULSE_EXT_CNT_EN
    logic [LPE_CNT_W-1:0] evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else if (cnt_clr) begin
            evt_q <= '0;
        end else if (edge_det && (evt_q != '1)) begin
            evt_q <= evt_q + 1'b1;
        end
    end

    assign evt_cnt = evt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign evt_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/led_pulse_extender.sv
`default_nettype none
// ============================================================================
// Module   : led_pulse_extender
// Purpose  : Multi-channel pulse extender for status LEDs. Each channel
//            stretches rising edges of an asynchronous input to a fixed hold
//            time, with an optional forced off-gap between holds.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            pulse_in   - N_CH asynchronous event inputs
//            pulse_out  - N_CH registered stretched outputs
//            active_any - registered OR of pulse_out (one cycle behind)
//            cnt_clr    - synchronous clear of all event counters
//            evt_cnt    - 16-bit accepted-edge counter per channel,
//                         channel k at [16k+15:16k]
// Config   : LED_PULSE_EXT_CNT_EN enables the event counters; otherwise
//            evt_cnt reads 0 and cnt_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module led_pulse_extender
    import led_pulse_ext_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 80_000_000,
    parameter int GAP_CYCLES  = 8_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int RETRIGGER   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           pulse_in,
    output logic [N_CH-1:0]           pulse_out,
    output logic                      active_any,
    input  logic                      cnt_clr,
    output logic [N_CH*LPE_CNT_W-1:0] evt_cnt
);

    if ((N_CH < 1) || (HOLD_CYCLES < 1) || (GAP_CYCLES < 0) || (SYNC_STAGES < 2) ||
        ((RETRIGGER != 0) && (RETRIGGER != 1))) begin : g_param_check
        $error("led_pulse_extender: illegal parameter value");
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        led_pulse_ext_ch #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .GAP_CYCLES  (GAP_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .RETRIGGER   (RETRIGGER)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pulse_in  (pulse_in[k]),
            .cnt_clr   (cnt_clr),
            .pulse_out (pulse_out[k]),
            .evt_cnt   (evt_cnt[k*LPE_CNT_W +: LPE_CNT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_any <= 1'b0;
        end else begin
            active_any <= |pulse_out;
        end
    end

endmodule
`default_nettype wire
